fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, meaning PC and address width.
REQ-002 SHALL have parameter INSTRUCTION_WIDTH, default 32, meaning fetched word width.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address.
REQ-004 SHALL have parameter HALT_INSTR, default 32'h0000_0000, meaning encoding that stops fetch.
REQ-005 SHALL have a single clock and an asynchronous active-low reset; all state SHALL be clocked on clk rising edge.
REQ-006 SHALL have port clk, input, 1, system clock.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port stall_i, input, 1, hold PC and IF/ID register.
REQ-009 SHALL have port pc_src_i, input, 1, redirect request (taken branch/jump).
REQ-010 SHALL have port target_i, input, ADDRESS_WIDTH, redirect address.
REQ-011 SHALL have port pc_o, output, ADDRESS_WIDTH, current PC to the instruction memory address input A.
REQ-012 SHALL have port instr_i, input, INSTRUCTION_WIDTH, word returned combinationally by the instruction memory for pc_o.
REQ-013 SHALL have ports if_id_pc_o and if_id_pc4_o, outputs, ADDRESS_WIDTH, registered PC and PC+4 of the captured instruction.
REQ-014 SHALL have port if_id_instr_o, output, INSTRUCTION_WIDTH, registered instruction.
REQ-015 SHALL have port if_id_valid_o, output, 1, IF/ID contents are a real instruction.
REQ-016 SHALL have ports halted_o and misalign_o, outputs, 1 each, halt state and sticky misaligned-target flag.

Function
REQ-017 SHALL implement states BOOT, RUN, HALT; pc_o driven from PC register only (no combinational path from any input).
REQ-018 BOOT: one cycle after reset release; captures nothing; if_id_valid_o=0; PC held; next state RUN unconditionally.
REQ-019 RUN, no stall, no redirect: IF/ID <= {pc, pc+4, instr_i}, valid <= 1, PC <= PC+4.
REQ-020 PC+4 SHALL wrap modulo 2^ADDRESS_WIDTH (FFFF_FFFC -> 0000_0000).
REQ-021 Priority each cycle: rst_n > pc_src_i > stall_i > normal advance.
REQ-022 pc_src_i=1 (RUN or HALT, regardless of stall_i): PC <= {target_i[ADDRESS_WIDTH-1:2],2'b00}; if_id_valid_o <= 0; other IF/ID fields hold; state <= RUN.
REQ-023 pc_src_i=1 with target_i[1:0]!=0 SHALL set misalign_o, which stays 1 until reset.
REQ-024 stall_i=1, pc_src_i=0: PC, IF/ID fields and valid all hold.
REQ-025 RUN capture where instr_i==HALT_INSTR: the halt word is captured with valid=1, PC does not advance, state <= HALT.
REQ-026 HALT: PC holds; if_id_valid_o <= 0 from the next cycle; halted_o=1; only pc_src_i or reset leave HALT.
REQ-027 halted_o SHALL be 1 exactly while state is HALT (registered, no glitches).

Reset
REQ-028 rst_n=0 SHALL immediately (asynchronously) force state BOOT, PC=RESET_PC, IF/ID pc/pc4/instr=0, if_id_valid_o=0, halted_o=0, misalign_o=0.
REQ-029 Reset asserted mid-stall, mid-redirect or in HALT SHALL produce the REQ-028 values with no residual state.
REQ-030 First capture after reset release SHALL be the word at RESET_PC, valid on the second rising edge.

Verification
REQ-031 Reset, memory words 0x00500093,0x00100113,0x00000000 at 0,4,8 -> pc_o 0,0,4,8; IF/ID valid from edge 2 with pc 0 instr 0x00500093; halted_o=1 after word at 8 captured; pc_o stays 8.
REQ-032 Stall for 3 cycles at pc 0x10 -> pc_o stays 0x10; IF/ID stays pc 0x0C; resumes with pc 0x10 captured next.
REQ-033 pc_src_i=1, target 0x40, with stall_i=1 same cycle -> pc_o=0x40 next cycle; if_id_valid_o=0 for one cycle; then pc 0x40 captured.
REQ-034 In HALT, pc_src_i=1 target 0x23 -> pc_o=0x20, misalign_o=1 sticky, halted_o=0, state RUN.
REQ-035 RESET_PC=0xFFFF_FFFC, non-halt word -> after one capture pc_o=0x0000_0000, if_id_pc4_o=0x0000_0000.
REQ-036 rst_n pulsed low mid-cycle while in HALT with misalign_o=1 -> all outputs reach REQ-028 values before the next clock edge.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the instruction memory address and
// registers each fetched word into the IF/ID pipeline register.
module fetch_unit #(
    parameter int unsigned                  ADDRESS_WIDTH     = 32,
    parameter int unsigned                  INSTRUCTION_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0]     RESET_PC          = 32'h0000_0000,
    parameter logic [INSTRUCTION_WIDTH-1:0] HALT_INSTR        = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall_i,
    input  logic                         pc_src_i,
    input  logic [ADDRESS_WIDTH-1:0]     target_i,
    output logic [ADDRESS_WIDTH-1:0]     pc_o,
    input  logic [INSTRUCTION_WIDTH-1:0] instr_i,
    output logic [ADDRESS_WIDTH-1:0]     if_id_pc_o,
    output logic [ADDRESS_WIDTH-1:0]     if_id_pc4_o,
    output logic [INSTRUCTION_WIDTH-1:0] if_id_instr_o,
    output logic                         if_id_valid_o,
    output logic                         halted_o,
    output logic                         misalign_o
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t                         state;
    logic [ADDRESS_WIDTH-1:0]       pc;
    logic [ADDRESS_WIDTH-1:0]       pc_plus4;
    logic [ADDRESS_WIDTH-1:0]       redirect_pc;
    logic                           target_misaligned;
    logic                           fetched_halt;

    // Natural-width add so the PC wraps at the top of the address space.
    assign pc_plus4          = pc + ADDRESS_WIDTH'(4);
    assign redirect_pc       = {target_i[ADDRESS_WIDTH-1:2], 2'b00};
    assign target_misaligned = |target_i[1:0];
    assign fetched_halt      = (instr_i == HALT_INSTR);

    assign pc_o = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= BOOT;
            pc            <= RESET_PC;
            if_id_pc_o    <= '0;
            if_id_pc4_o   <= '0;
            if_id_instr_o <= '0;
            if_id_valid_o <= 1'b0;
            halted_o      <= 1'b0;
            misalign_o    <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state         <= RUN;
                    if_id_valid_o <= 1'b0;
                end

                RUN: begin
                    if (pc_src_i) begin
                        pc            <= redirect_pc;
                        if_id_valid_o <= 1'b0;
                        if (target_misaligned) begin
                            misalign_o <= 1'b1;
                        end
                    end else if (!stall_i) begin
                        if_id_pc_o    <= pc;
                        if_id_pc4_o   <= pc_plus4;
                        if_id_instr_o <= instr_i;
                        if_id_valid_o <= 1'b1;
                        // A halt word is delivered downstream but the PC parks on it.
                        if (fetched_halt) begin
                            state    <= HALT;
                            halted_o <= 1'b1;
                        end else begin
                            pc <= pc_plus4;
                        end
                    end
                end

                HALT: begin
                    if_id_valid_o <= 1'b0;
                    if (pc_src_i) begin
                        pc       <= redirect_pc;
                        state    <= RUN;
                        halted_o <= 1'b0;
                        if (target_misaligned) begin
                            misalign_o <= 1'b1;
                        end
                    end
                end

                default: begin
                    state         <= BOOT;
                    if_id_valid_o <= 1'b0;
                    halted_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, asynchronous reset check in HALT,
// then randomized redirect/stall traffic checked against a behavioural fetch model.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        pc_src;
    logic [31:0] target;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        halted;
    logic        misalign;

    logic [31:0] wrap_pc;
    logic [31:0] wrap_if_id_pc;
    logic [31:0] wrap_if_id_pc4;
    logic [31:0] wrap_if_id_instr;
    logic        wrap_if_id_valid;
    logic        wrap_halted;
    logic        wrap_misalign;

    logic [31:0] mem [256];

    int checks;
    int failures;

    typedef struct {
        logic        stall;
        logic        src;
        logic [31:0] target;
        logic [31:0] pc;
        logic        valid;
        logic [31:0] ifpc;
        logic [31:0] instr;
        logic        halted;
        logic        mis;
    } vec_t;

    vec_t vecs [17];

    fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall),
        .pc_src_i      (pc_src),
        .target_i      (target),
        .pc_o          (pc),
        .instr_i       (instr),
        .if_id_pc_o    (if_id_pc),
        .if_id_pc4_o   (if_id_pc4),
        .if_id_instr_o (if_id_instr),
        .if_id_valid_o (if_id_valid),
        .halted_o      (halted),
        .misalign_o    (misalign)
    );

    // Second instance starts at the top of the address space to exercise PC wrap.
    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (1'b0),
        .pc_src_i      (1'b0),
        .target_i      (32'h0),
        .pc_o          (wrap_pc),
        .instr_i       (32'h0000_0013),
        .if_id_pc_o    (wrap_if_id_pc),
        .if_id_pc4_o   (wrap_if_id_pc4),
        .if_id_instr_o (wrap_if_id_instr),
        .if_id_valid_o (wrap_if_id_valid),
        .halted_o      (wrap_halted),
        .misalign_o    (wrap_misalign)
    );

    assign instr = mem[pc[9:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic r, input logic [31:0] t);
        stall  = s;
        pc_src = r;
        target = t;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " pc"}, pc, 32'h0);
        checkOutput({tag, " valid"}, {31'b0, if_id_valid}, 32'h0);
        checkOutput({tag, " ifpc"}, if_id_pc, 32'h0);
        checkOutput({tag, " ifpc4"}, if_id_pc4, 32'h0);
        checkOutput({tag, " instr"}, if_id_instr, 32'h0);
        checkOutput({tag, " halted"}, {31'b0, halted}, 32'h0);
        checkOutput({tag, " misalign"}, {31'b0, misalign}, 32'h0);
    endtask

    // Behavioural model state for the random phase.
    logic [31:0] m_pc, m_ifpc, m_ifpc4, m_instr, m_word;
    logic        m_valid, m_halted, m_mis, m_booting;
    logic        r_stall, r_src;
    logic [31:0] r_target;

    initial begin
        stall  = 1'b0;
        pc_src = 1'b0;
        target = 32'h0;
        rst_n  = 1'b0;
        checks   = 0;
        failures = 0;

        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013 | (i << 20);
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0010_0113;
        mem[2] = 32'h0000_0000;

        //             stall  src    target        pc            valid  ifpc          instr         halted mis
        vecs[0]  = '{1'b0, 1'b0, 32'h0,       32'h00,       1'b0, 32'h00,       32'h0,        1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,       32'h04,       1'b1, 32'h00,       32'h0050_0093, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,       32'h08,       1'b1, 32'h04,       32'h0010_0113, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,       32'h08,       1'b1, 32'h08,       32'h0,        1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,       32'h08,       1'b0, 32'h08,       32'h0,        1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 32'h23,      32'h20,       1'b0, 32'h08,       32'h0,        1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,       32'h24,       1'b1, 32'h20,       32'h0080_0013, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 32'h0C,      32'h0C,       1'b0, 32'h20,       32'h0080_0013, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,       32'h10,       1'b1, 32'h0C,       32'h0030_0013, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 32'h0,       32'h10,       1'b1, 32'h0C,       32'h0030_0013, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 32'h0,       32'h10,       1'b1, 32'h0C,       32'h0030_0013, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 32'h0,       32'h10,       1'b1, 32'h0C,       32'h0030_0013, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 32'h0,       32'h14,       1'b1, 32'h10,       32'h0040_0013, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 32'h40,      32'h40,       1'b0, 32'h10,       32'h0040_0013, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 32'h0,       32'h44,       1'b1, 32'h40,       32'h0100_0013, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 32'h08,      32'h08,       1'b0, 32'h40,       32'h0100_0013, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 32'h0,       32'h08,       1'b1, 32'h08,       32'h0,        1'b1, 1'b1};

        #12;
        checkResetValues("reset");
        checkOutput("wrap reset pc", wrap_pc, 32'hFFFF_FFFC);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].stall, vecs[i].src, vecs[i].target);
            checkOutput($sformatf("vec%0d pc", i), pc, vecs[i].pc);
            checkOutput($sformatf("vec%0d valid", i), {31'b0, if_id_valid}, {31'b0, vecs[i].valid});
            checkOutput($sformatf("vec%0d ifpc", i), if_id_pc, vecs[i].ifpc);
            checkOutput($sformatf("vec%0d ifpc4", i), if_id_pc4, (i == 0) ? 32'h0 : vecs[i].ifpc + 32'h4);
            checkOutput($sformatf("vec%0d instr", i), if_id_instr, vecs[i].instr);
            checkOutput($sformatf("vec%0d halted", i), {31'b0, halted}, {31'b0, vecs[i].halted});
            checkOutput($sformatf("vec%0d misalign", i), {31'b0, misalign}, {31'b0, vecs[i].mis});
            if (i == 0) checkOutput("wrap boot pc", wrap_pc, 32'hFFFF_FFFC);
            if (i == 1) begin
                checkOutput("wrap pc", wrap_pc, 32'h0);
                checkOutput("wrap ifpc", wrap_if_id_pc, 32'hFFFF_FFFC);
                checkOutput("wrap ifpc4", wrap_if_id_pc4, 32'h0);
                checkOutput("wrap valid", {31'b0, wrap_if_id_valid}, 32'h1);
            end
        end

        // Asynchronous reset pulsed mid-cycle while halted with misalign set.
        stall  = 1'b0;
        pc_src = 1'b0;
        #2 rst_n = 1'b0;
        #1 checkResetValues("async reset");

        for (int i = 0; i < 256; i++) begin
            mem[i] = ($urandom_range(0, 11) == 0) ? 32'h0 : ($urandom | 32'h1);
        end
        @(negedge clk);
        rst_n = 1'b1;

        m_pc = 32'h0; m_ifpc = 32'h0; m_ifpc4 = 32'h0; m_instr = 32'h0;
        m_valid = 1'b0; m_halted = 1'b0; m_mis = 1'b0; m_booting = 1'b1;

        for (int cyc = 0; cyc < 400; cyc++) begin
            r_stall  = ($urandom_range(0, 9) < 3);
            r_src    = m_halted ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 99) < 12);
            r_target = 32'($urandom_range(0, 1023));
            m_word   = mem[m_pc[9:2]];

            if (m_booting) begin
                m_booting = 1'b0;
            end else if (r_src) begin
                m_pc     = r_target & 32'hFFFF_FFFC;
                m_valid  = 1'b0;
                m_halted = 1'b0;
                if (r_target[1:0] != 2'b00) m_mis = 1'b1;
            end else if (m_halted) begin
                m_valid = 1'b0;
            end else if (!r_stall) begin
                m_ifpc  = m_pc;
                m_ifpc4 = m_pc + 32'h4;
                m_instr = m_word;
                m_valid = 1'b1;
                if (m_word == 32'h0) m_halted = 1'b1;
                else                 m_pc = m_pc + 32'h4;
            end

            applyStimulus(r_stall, r_src, r_target);
            checkOutput($sformatf("rand%0d pc", cyc), pc, m_pc);
            checkOutput($sformatf("rand%0d valid", cyc), {31'b0, if_id_valid}, {31'b0, m_valid});
            checkOutput($sformatf("rand%0d ifpc", cyc), if_id_pc, m_ifpc);
            checkOutput($sformatf("rand%0d ifpc4", cyc), if_id_pc4, m_ifpc4);
            checkOutput($sformatf("rand%0d instr", cyc), if_id_instr, m_instr);
            checkOutput($sformatf("rand%0d halted", cyc), {31'b0, halted}, {31'b0, m_halted});
            checkOutput($sformatf("rand%0d misalign", cyc), {31'b0, misalign}, {31'b0, m_mis});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
